// File: rtl/i2s_apb_pkg.sv
// -----------------------------------------------------------------------------
// i2s_apb_pkg
// Shared definitions for the APB-side I2S transfer scheduler:
//   - decoded APB register addresses
//   - bit positions of the status register
//   - TX and RX holding-register state encodings
// -----------------------------------------------------------------------------
package i2s_apb_pkg;

  localparam logic [31:0] ADDR_TXDATA = 32'h4;
  localparam logic [31:0] ADDR_RXDATA = 32'h8;
  localparam logic [31:0] ADDR_STATUS = 32'hC;

  // Status register layout: {tx_busy, rx_valid, tx_full, rx_empty}
  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_VALID = 2;
  localparam int STAT_TX_BUSY  = 3;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_HOLD = 1'b1
  } tx_state_t;

  typedef enum logic [1:0] {
    R_EMPTY = 2'd0,
    R_FETCH = 2'd1,
    R_VALID = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_apb_fifo_sched_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Saturating wait-state counter used to bound stalled RX data reads.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : count one more wait cycle (ignored once expired)
//   clr       : return to zero (has priority over inc)
//   expired   : counter has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/i2s_apb_fifo_sched.sv
// -----------------------------------------------------------------------------
// i2s_apb_fifo_sched
// APB-side transfer scheduler between the APB slave port and the I2S TX/RX
// sample FIFOs. Owns a one-word TX holding register (pushed into the TX FIFO
// when it has room) and a one-word RX holding register (prefetched from the
// RX FIFO). APB accesses are stretched with pready wait states while a holding
// register is not ready; a stalled RX data read ends with pslverr after a
// bounded number of wait cycles.
//
// Handshakes:
//   APB access cycle is psel && penable; it completes in the cycle pready=1.
//   pready/prdata/pslverr are combinational and are 0 outside an access.
//   tx_wen is a one-cycle push strobe carrying tx_wdata, never while tx_full.
//   rx_ren is a one-cycle pop strobe; rx_rdata is sampled the following cycle.
//
// Ports:
//   pclk, preset                      : clock, asynchronous active-high reset
//   psel, penable, pwrite, paddr,
//   pwdata, prdata, pready, pslverr   : APB slave
//   tx_full, tx_wen, tx_wdata         : TX FIFO push side
//   rx_empty, rx_ren, rx_rdata        : RX FIFO pop side
//   dbg_tx_state, dbg_rx_state        : current TX / RX FSM states
// -----------------------------------------------------------------------------
module i2s_apb_fifo_sched
  import i2s_apb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [31:0]   paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr,
  input  logic          tx_full,
  output logic          tx_wen,
  output logic [DW-1:0] tx_wdata,
  input  logic          rx_empty,
  output logic          rx_ren,
  input  logic [DW-1:0] rx_rdata,
  output logic          dbg_tx_state,
  output logic [1:0]    dbg_rx_state
);

  tx_state_t     tx_state_q, tx_state_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [DW-1:0] tx_hold_q, tx_hold_d;
  logic [DW-1:0] rx_hold_q, rx_hold_d;

  logic access, hit_tx, hit_rx, hit_st;
  logic tmr_inc, tmr_clr, tmr_expired;
  logic tx_push, rx_pop;

  assign access = psel && penable;
  assign hit_tx = access &&  pwrite && (paddr == ADDR_TXDATA);
  assign hit_rx = access && !pwrite && (paddr == ADDR_RXDATA);
  assign hit_st = access && !pwrite && (paddr == ADDR_STATUS);

  assign dbg_tx_state = tx_state_q;
  assign dbg_rx_state = rx_state_q;

  // TX holding register: capture on an accepted write, push when FIFO has room.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_hold_d  = tx_hold_q;
    tx_push    = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (hit_tx) begin
          tx_hold_d  = pwdata;
          tx_state_d = T_HOLD;
        end
      end
      T_HOLD: begin
        if (!tx_full) begin
          tx_push    = 1'b1;
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  assign tx_wen   = tx_push;
  assign tx_wdata = tx_push ? tx_hold_q : '0;

  // RX holding register: pop, capture the word one cycle later, hold until read.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_hold_d  = rx_hold_q;
    rx_pop     = 1'b0;
    case (rx_state_q)
      R_EMPTY: begin
        if (!rx_empty) begin
          rx_pop     = 1'b1;
          rx_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rx_hold_d  = rx_rdata;
        rx_state_d = R_VALID;
      end
      R_VALID: begin
        if (hit_rx) begin
          rx_state_d = R_EMPTY;
        end
      end
      default: rx_state_d = R_EMPTY;
    endcase
  end

  // The pop strobe is held off while reset is asserted so that the FIFO never
  // sees a pop from a scheduler that is being cleared.
  assign rx_ren = rx_pop && !preset;

  // APB response. Everything not stalled below completes immediately.
  always_comb begin
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    tmr_inc = 1'b0;
    if (access) begin
      pready = 1'b1;
      if (hit_tx && (tx_state_q == T_HOLD)) begin
        pready = 1'b0;
      end
      if (hit_rx) begin
        if (rx_state_q == R_VALID) begin
          prdata = rx_hold_q;
        end else if (tmr_expired) begin
          pslverr = 1'b1;
        end else begin
          pready  = 1'b0;
          tmr_inc = 1'b1;
        end
      end
      if (hit_st) begin
        prdata[STAT_TX_BUSY]  = (tx_state_q != T_IDLE);
        prdata[STAT_RX_VALID] = (rx_state_q == R_VALID);
        prdata[STAT_TX_FULL]  = tx_full;
        prdata[STAT_RX_EMPTY] = rx_empty;
      end
    end
  end

  assign tmr_clr = !psel || (access && pready);

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (pclk),
    .rst     (preset),
    .inc     (tmr_inc),
    .clr     (tmr_clr),
    .expired (tmr_expired)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tx_state_q <= T_IDLE;
      rx_state_q <= R_EMPTY;
      tx_hold_q  <= '0;
      rx_hold_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_hold_q  <= tx_hold_d;
      rx_hold_q  <= rx_hold_d;
    end
  end

endmodule

// File: tb/tb_i2s_apb_fifo_sched.sv
// -----------------------------------------------------------------------------
// tb_i2s_apb_fifo_sched
// Bench for i2s_apb_fifo_sched (DW=32, TIMEOUT=16): a vector table from reset,
// hand-written multi-cycle sequences, then randomized APB/FIFO traffic checked
// against a queue-based model of the holding registers.
// -----------------------------------------------------------------------------
module tb_i2s_apb_fifo_sched;
  import i2s_apb_pkg::*;

  localparam int TIMEOUT = 16;

  logic        pclk;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        tx_full, tx_wen;
  logic [31:0] tx_wdata;
  logic        rx_empty, rx_ren;
  logic [31:0] rx_rdata;
  logic        dbg_tx_state;
  logic [1:0]  dbg_rx_state;

  int n_vec = 0;
  int n_err = 0;

  // Model of the holding registers: each holds at most one word.
  logic [31:0] exp_q[$];   // word accepted by a TX write, waiting for its push
  logic [31:0] rx_q[$];    // word prefetched from the RX FIFO, waiting for a read
  bit          rx_inflight;
  int          m_waits;
  bit          m_pready;

  logic [31:0] bad_addr[6] = '{32'h0, 32'h10, 32'h14, 32'h4, 32'h8, 32'hC};
  logic        bad_wr[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  typedef struct {
    logic        sel, en, wr;
    logic [31:0] addr, wdata;
    logic        txf, rxe;
    logic        e_pready;
    logic [31:0] e_prdata;
    logic        e_pslverr, e_wen;
    logic [31:0] e_wdata;
    logic        e_ren;
  } vec_t;

  vec_t tbl[11];

  i2s_apb_fifo_sched #(.DW(32), .TIMEOUT(TIMEOUT)) dut (
    .pclk         (pclk),
    .preset       (preset),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr),
    .tx_full      (tx_full),
    .tx_wen       (tx_wen),
    .tx_wdata     (tx_wdata),
    .rx_empty     (rx_empty),
    .rx_ren       (rx_ren),
    .rx_rdata     (rx_rdata),
    .dbg_tx_state (dbg_tx_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic settle();
    #5;
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  task automatic bus_setup(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    rx_q.delete();
    rx_inflight = 1'b0;
    m_waits     = 0;
  endtask

  task automatic do_reset();
    tick();
    preset = 1'b1; bus_idle(); tx_full = 1'b0; rx_empty = 1'b1; rx_rdata = '0;
    tick();
    tick();
    preset = 1'b0;
    model_clear();
  endtask

  // RX data read: setup, then access until pready (bounded).
  task automatic rx_read(output int waits, output logic [31:0] data,
                         output logic err, output bit ok);
    waits = 0; data = '0; err = 1'b0; ok = 1'b0;
    tick();
    bus_setup(1'b0, ADDR_RXDATA, 32'h0);
    tick();
    penable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      settle();
      chk("rx_ren_quiet", rx_ren, 1'b0);
      if (pready) begin
        data = prdata; err = pslverr; ok = 1'b1;
        break;
      end
      waits++;
      tick();
    end
    tick();
    bus_idle();
  endtask

  // ---------------- scoreboard / reference model ----------------
  task automatic model_step();
    logic        acc, wr4, rd8, rdc, tx_busy, rx_full;
    logic        e_wen, e_ren, e_pready, e_pslverr;
    logic [31:0] e_prdata, e_wdata;
    acc     = psel && penable;
    wr4     = acc &&  pwrite && (paddr == ADDR_TXDATA);
    rd8     = acc && !pwrite && (paddr == ADDR_RXDATA);
    rdc     = acc && !pwrite && (paddr == ADDR_STATUS);
    tx_busy = (exp_q.size() != 0);
    rx_full = (rx_q.size() != 0);

    e_wen   = tx_busy && !tx_full;
    e_wdata = '0;
    if (e_wen) e_wdata = exp_q[0];
    e_ren   = !rx_inflight && !rx_full && !rx_empty;

    e_pready = acc; e_prdata = '0; e_pslverr = 1'b0;
    if (wr4 && tx_busy) e_pready = 1'b0;
    if (rd8) begin
      if (rx_full)                     e_prdata  = rx_q[0];
      else if (m_waits == TIMEOUT - 1) e_pslverr = 1'b1;
      else                             e_pready  = 1'b0;
    end
    if (rdc) e_prdata = {28'd0, tx_busy, rx_full, tx_full, rx_empty};

    chk("rnd_pready",   pready,   e_pready);
    chk("rnd_prdata",   prdata,   e_prdata);
    chk("rnd_pslverr",  pslverr,  e_pslverr);
    chk("rnd_tx_wen",   tx_wen,   e_wen);
    chk("rnd_tx_wdata", tx_wdata, e_wdata);
    chk("rnd_rx_ren",   rx_ren,   e_ren);

    if (e_wen)                   void'(exp_q.pop_front());
    else if (!tx_busy && wr4)    exp_q.push_back(pwdata);

    if (rx_inflight) begin
      rx_q.push_back(rx_rdata);
      rx_inflight = 1'b0;
    end else if (e_ren) begin
      rx_inflight = 1'b1;
    end else if (rx_full && rd8) begin
      void'(rx_q.pop_front());
    end

    if (!psel || (acc && e_pready)) m_waits = 0;
    else if (rd8 && !rx_full)       m_waits++;

    m_pready = e_pready;
  endtask

  task automatic rcycle(input logic sel, input logic en, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
    tick();
    psel = sel; penable = en; pwrite = wr; paddr = addr; pwdata = data;
    tx_full  = ($urandom_range(0, 3) == 0);
    rx_empty = ($urandom_range(0, 2) == 0);
    rx_rdata = $urandom;
    settle();
    model_step();
  endtask

  // ---------------- test ----------------
  initial begin
    int          w;
    logic [31:0] d;
    logic        e;
    bit          ok;

    preset = 1'b1;
    bus_idle();
    tx_full = 1'b0; rx_empty = 1'b1; rx_rdata = '0;
    model_clear();

    //          sel  en   wr   addr    wdata         txf  rxe  rdy  prdata  err  wen  wdata         ren
    tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0,        1'b0,1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,32'hC,  32'h0,        1'b0,1'b1,1'b1,32'h1,  1'b0,1'b0,32'h0,        1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b0,32'h10, 32'h0,        1'b0,1'b1,1'b1,32'h0,  1'b0,1'b0,32'h0,        1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b1,32'h8,  32'hFFFF,     1'b0,1'b1,1'b1,32'h0,  1'b0,1'b0,32'h0,        1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,32'h4,  32'h0,        1'b0,1'b1,1'b1,32'h0,  1'b0,1'b0,32'h0,        1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b1,32'h4,  32'hA5A50001, 1'b0,1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,32'h4,  32'hA5A50001, 1'b0,1'b1,1'b1,32'h0,  1'b0,1'b0,32'h0,        1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0,        1'b0,1'b1,1'b0,32'h0,  1'b0,1'b1,32'hA5A50001, 1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0,        1'b0,1'b1,1'b0,32'h0,  1'b0,1'b0,32'h0,        1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b0,32'hC,  32'h0,        1'b1,1'b1,1'b1,32'h3,  1'b0,1'b0,32'h0,        1'b0};
    tbl[10] = '{1'b1,1'b1,1'b1,32'hC,  32'h5,        1'b0,1'b1,1'b1,32'h0,  1'b0,1'b0,32'h0,        1'b0};

    // Reset state, checked while reset is held.
    tick();
    tick();
    settle();
    chk("rst_tx_wen",   tx_wen,       1'b0);
    chk("rst_tx_wdata", tx_wdata,     32'h0);
    chk("rst_rx_ren",   rx_ren,       1'b0);
    chk("rst_pready",   pready,       1'b0);
    chk("rst_prdata",   prdata,       32'h0);
    chk("rst_pslverr",  pslverr,      1'b0);
    chk("rst_tx_state", dbg_tx_state, T_IDLE);
    chk("rst_rx_state", dbg_rx_state, R_EMPTY);
    preset = 1'b0;

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      tick();
      psel = tbl[i].sel; penable = tbl[i].en; pwrite = tbl[i].wr;
      paddr = tbl[i].addr; pwdata = tbl[i].wdata;
      tx_full = tbl[i].txf; rx_empty = tbl[i].rxe;
      settle();
      chk($sformatf("tbl%0d_pready", i),   pready,   tbl[i].e_pready);
      chk($sformatf("tbl%0d_prdata", i),   prdata,   tbl[i].e_prdata);
      chk($sformatf("tbl%0d_pslverr", i),  pslverr,  tbl[i].e_pslverr);
      chk($sformatf("tbl%0d_tx_wen", i),   tx_wen,   tbl[i].e_wen);
      chk($sformatf("tbl%0d_tx_wdata", i), tx_wdata, tbl[i].e_wdata);
      chk($sformatf("tbl%0d_rx_ren", i),   rx_ren,   tbl[i].e_ren);
    end

    // TX back-pressure: second write stalls until tx_full drops.
    tick(); bus_setup(1'b1, ADDR_TXDATA, 32'h11); tx_full = 1'b1;
    tick(); penable = 1'b1; settle();
    chk("bp_wr1_pready", pready, 1'b1);
    tick(); bus_setup(1'b1, ADDR_TXDATA, 32'h22); settle();
    chk("bp_full_wen", tx_wen, 1'b0);
    tick(); penable = 1'b1; settle();
    chk("bp_wr2_stall", pready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("bp_wr2_stall_n", pready, 1'b0);
      chk("bp_full_wen_n",  tx_wen, 1'b0);
    end
    tick(); tx_full = 1'b0; settle();
    chk("bp_push1_wen",   tx_wen,   1'b1);
    chk("bp_push1_data",  tx_wdata, 32'h11);
    chk("bp_push1_stall", pready,   1'b0);
    tick(); settle();
    chk("bp_wr2_done",  pready, 1'b1);
    chk("bp_wen_gap",   tx_wen, 1'b0);
    tick(); bus_idle(); settle();
    chk("bp_push2_wen",  tx_wen,   1'b1);
    chk("bp_push2_data", tx_wdata, 32'h22);
    tick(); settle();
    chk("bp_push2_single", tx_wen, 1'b0);

    // RX prefetch.
    tick(); rx_empty = 1'b0; settle();
    chk("pf_ren", rx_ren, 1'b1);
    tick(); rx_empty = 1'b1; rx_rdata = 32'hDEADBEEF; settle();
    chk("pf_ren_once",   rx_ren,       1'b0);
    chk("pf_state_fetch", dbg_rx_state, R_FETCH);
    tick(); rx_rdata = 32'h12345678; settle();
    chk("pf_state_valid", dbg_rx_state, R_VALID);
    chk("pf_ren_none",    rx_ren,       1'b0);
    rx_read(w, d, e, ok);
    chk("pf_ok",    ok, 1'b1);
    chk("pf_waits", w,  0);
    chk("pf_data",  d,  32'hDEADBEEF);
    chk("pf_err",   e,  1'b0);
    settle();
    chk("pf_state_empty", dbg_rx_state, R_EMPTY);

    // RX timeout, after an abandoned stalled read that must clear the counter.
    tick(); bus_setup(1'b0, ADDR_RXDATA, 32'h0);
    tick(); penable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("ab_wait", pready, 1'b0);
      tick();
    end
    bus_idle();
    rx_read(w, d, e, ok);
    chk("to_ok",    ok, 1'b1);
    chk("to_waits", w,  TIMEOUT - 1);
    chk("to_err",   e,  1'b1);
    chk("to_data",  d,  32'h0);

    // Status 0xE with T_HOLD, R_VALID, tx_full=1, rx_empty=0; bad address.
    tick(); tx_full = 1'b1; bus_setup(1'b1, ADDR_TXDATA, 32'h33);
    tick(); penable = 1'b1; settle();
    chk("st_wr_pready", pready, 1'b1);
    tick(); bus_idle(); rx_empty = 1'b0; settle();
    chk("st_ren", rx_ren, 1'b1);
    tick(); rx_rdata = 32'hCAFE0001;
    tick(); bus_setup(1'b0, ADDR_STATUS, 32'h0);
    tick(); penable = 1'b1; settle();
    chk("st_prdata", prdata, 32'hE);
    chk("st_pready", pready, 1'b1);
    tick(); bus_setup(1'b0, 32'h10, 32'h0);
    tick(); penable = 1'b1; settle();
    chk("bad_prdata",  prdata,  32'h0);
    chk("bad_pready",  pready,  1'b1);
    chk("bad_pslverr", pslverr, 1'b0);
    tick(); bus_idle(); settle();
    chk("bad_tx_state", dbg_tx_state, T_HOLD);
    chk("bad_rx_state", dbg_rx_state, R_VALID);

    // Consume the RX word, refetch, then reset while in T_HOLD / R_FETCH.
    tick(); bus_setup(1'b0, ADDR_RXDATA, 32'h0);
    tick(); penable = 1'b1; settle();
    chk("rm_rd_data", prdata, 32'hCAFE0001);
    tick(); bus_idle(); settle();
    chk("rm_ren", rx_ren, 1'b1);
    tick(); tx_full = 1'b0; settle();
    chk("rm_state_fetch", dbg_rx_state, R_FETCH);
    chk("rm_wen_pre",     tx_wen,       1'b1);
    preset = 1'b1;
    #1;
    chk("rm_wen_rst",      tx_wen,       1'b0);
    chk("rm_ren_rst",      rx_ren,       1'b0);
    chk("rm_wdata_rst",    tx_wdata,     32'h0);
    chk("rm_tx_state_rst", dbg_tx_state, T_IDLE);
    chk("rm_rx_state_rst", dbg_rx_state, R_EMPTY);
    rx_empty = 1'b1;
    tick(); preset = 1'b0;
    tick(); bus_setup(1'b0, ADDR_STATUS, 32'h0);
    tick(); penable = 1'b1; settle();
    chk("rm_status", prdata, 32'h1);
    chk("rm_no_push", tx_wen, 1'b0);
    tick(); bus_idle();

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 300; t++) begin
      int          op;
      int          k;
      logic        wr;
      logic [31:0] addr, data;
      bit          done, aborted;
      op   = $urandom_range(0, 9);
      data = $urandom;
      wr   = 1'b0;
      addr = ADDR_STATUS;
      if (op <= 2)      begin wr = 1'b1; addr = ADDR_TXDATA; end
      else if (op <= 5) begin wr = 1'b0; addr = ADDR_RXDATA; end
      else if (op == 7) begin
        k = $urandom_range(0, 5);
        wr = bad_wr[k]; addr = bad_addr[k];
      end
      if (op >= 8) begin
        repeat ($urandom_range(1, 3)) rcycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end else begin
        rcycle(1'b1, 1'b0, wr, addr, data);
        done = 1'b0; aborted = 1'b0;
        for (int c = 0; c < 40 && !done && !aborted; c++) begin
          rcycle(1'b1, 1'b1, wr, addr, data);
          if (m_pready) done = 1'b1;
          else if ($urandom_range(0, 15) == 0) aborted = 1'b1;
        end
        chk("rnd_bound", done || aborted, 1'b1);
        rcycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
